// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the Basic Computer memory access controller.
// The wait-counter width covers the full supported READ_LATENCY range (1..4).
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF       = 12;
  localparam int DATA_W_DEF       = 16;
  localparam int READ_LATENCY_MAX = 4;
  localparam int WAIT_CNT_W       = $clog2(READ_LATENCY_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IND_RD,
    ST_IND_WAIT,
    ST_ACC_RD,
    ST_ACC_WAIT,
    ST_ACC_WR,
    ST_RESP
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus shared-address block-RAM port.
// slave = controller view, master = CPU control unit and RAM view.
interface mem_access_ctrl_if import mem_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_ind;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_ea;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_ind, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_ea, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_ind, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_ea, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_lat_wait.sv
// Loadable down-counter: after load, done rises LATENCY cycles later and
// stays high until the next load.
module mem_lat_wait import mem_ctrl_pkg::*; #(
  parameter int LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam logic [WAIT_CNT_W-1:0] LOAD_VAL = WAIT_CNT_W'(LATENCY);
  localparam logic [WAIT_CNT_W-1:0] ONE      = WAIT_CNT_W'(1);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side memory sequencer: single-word loads/stores with optional one-level
// indirection. Optional MEM_STATS_EN adds saturating read/write access counters.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  mem_access_ctrl_if.slave        bus
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]             stat_reads,
  output logic [15:0]             stat_writes
`endif
);

  state_e            state_q,     state_d;
  logic              write_q,     write_d;
  logic [ADDR_W-1:0] ea_q,        ea_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] rsp_ea_q,    rsp_ea_d;
  logic              wait_load;
  logic              wait_done;

  mem_lat_wait #(
    .LATENCY (READ_LATENCY)
  ) u_wait (
    .clock (clock),
    .reset (reset),
    .load  (wait_load),
    .done  (wait_done)
  );

  // mem_write is only ever set on entry to ACC_WR, so read states never write.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    ea_d        = ea_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_ea_d    = rsp_ea_q;
    wait_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d     = bus.req_write;
          ea_d        = bus.req_addr;
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_wdata;
          if (bus.req_ind) begin
            state_d   = ST_IND_RD;
            wait_load = 1'b1;
          end else if (bus.req_write) begin
            state_d     = ST_ACC_WR;
            mem_write_d = 1'b1;
          end else begin
            state_d   = ST_ACC_RD;
            wait_load = 1'b1;
          end
        end
      end
      ST_IND_RD: begin
        state_d = ST_IND_WAIT;
      end
      ST_IND_WAIT: begin
        if (wait_done) begin
          ea_d       = bus.mem_rdata[ADDR_W-1:0];
          mem_addr_d = bus.mem_rdata[ADDR_W-1:0];
          if (write_q) begin
            state_d     = ST_ACC_WR;
            mem_write_d = 1'b1;
          end else begin
            state_d   = ST_ACC_RD;
            wait_load = 1'b1;
          end
        end
      end
      ST_ACC_RD: begin
        state_d = ST_ACC_WAIT;
      end
      ST_ACC_WAIT: begin
        if (wait_done) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.mem_rdata;
          rsp_ea_d    = ea_q;
        end
      end
      ST_ACC_WR: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_ea_d    = ea_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      ea_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_ea_q    <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      ea_q        <= ea_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_ea_q    <= rsp_ea_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_ea    = rsp_ea_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef MEM_STATS_EN
  logic [15:0] stat_reads_q,  stat_reads_d;
  logic [15:0] stat_writes_q, stat_writes_d;

  // ACC_RD lasts exactly one cycle, so counting its cycles counts its entries.
  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    if (state_q == ST_ACC_RD) begin
      stat_reads_d = sat_inc16(stat_reads_q);
    end
    if (state_q == ST_ACC_WR) begin
      stat_writes_d = sat_inc16(stat_writes_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl against a behavioural synchronous RAM.
// Stat counter checks are compiled in only when MEM_STATS_EN is defined.
module tb_mem_access_ctrl;

  localparam int RL = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_access_ctrl_if #(.ADDR_W(12), .DATA_W(16)) bus ();

`ifdef MEM_STATS_EN
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
`endif

  mem_access_ctrl #(
    .ADDR_W       (12),
    .DATA_W       (16),
    .READ_LATENCY (RL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous RAM: address sampled at the edge, data valid RL cycles later.
  logic [15:0] mem [0:4095];
  logic [15:0] rd_pipe [0:RL-1];

  always @(posedge clock) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rdata = rd_pipe[RL-1];

  typedef struct {
    logic        write;
    logic        ind;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [11:0] exp_ea;
    int          exp_lat;
    int          exp_wr_cycles;
    int          exp_wr_lat;
    logic [11:0] exp_wr_addr;
  } vec_t;

  vec_t vecs [9];

  int tests = 0;
  int fails = 0;

  // Results of the most recent applyStimulus call.
  logic        got_rsp;
  int          got_lat;
  logic [15:0] got_rdata;
  logic [11:0] got_ea;
  int          wr_cycles;
  int          wr_lat;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        rsp_after;
  logic        ready_after;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one request from a negedge and follows it to its response pulse.
  task automatic applyStimulus(input logic write, input logic ind,
                               input logic [11:0] addr, input logic [15:0] wdata);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_ind   = ind;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    got_lat   = 0;
    wr_cycles = 0;
    wr_lat    = 0;
    wr_addr   = '0;
    wr_data   = '0;
    do begin
      @(negedge clock);
      got_lat++;
      if (got_lat == 1) begin
        bus.req_valid = 1'b0;
        bus.req_write = ~write;
        bus.req_addr  = ~addr;
      end
      if (bus.mem_write) begin
        wr_cycles++;
        wr_lat  = got_lat;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_wdata;
      end
    end while (!bus.rsp_valid && got_lat < 40);
    got_rsp   = bus.rsp_valid;
    got_rdata = bus.rsp_rdata;
    got_ea    = bus.rsp_ea;
    @(negedge clock);
    rsp_after   = bus.rsp_valid;
    ready_after = bus.req_ready;
  endtask

  int acc, rsp_cnt, wr_cnt, stall, last_acc, bad_rd;
  logic drop;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_ind   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h020] = 16'hF0AB;
    mem[12'h0AB] = 16'h5555;
    mem[12'h030] = 16'h0FFF;

    vecs[0] = '{1'b1, 1'b0, 12'h010, 16'h1234, 16'h0000, 12'h010, RL*0+2, 1, 1,      12'h010};
    vecs[1] = '{1'b0, 1'b0, 12'h010, 16'h0000, 16'h1234, 12'h010, RL+2,   0, 0,      12'h000};
    vecs[2] = '{1'b0, 1'b1, 12'h020, 16'h0000, 16'h5555, 12'h0AB, 2*RL+3, 0, 0,      12'h000};
    vecs[3] = '{1'b1, 1'b1, 12'h030, 16'hBEEF, 16'h0000, 12'hFFF, RL+3,   1, RL+2,   12'hFFF};
    vecs[4] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF, 12'hFFF, RL+2,   0, 0,      12'h000};
    vecs[5] = '{1'b1, 1'b0, 12'h000, 16'hA5A5, 16'h0000, 12'h000, 2,      1, 1,      12'h000};
    vecs[6] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'hA5A5, 12'h000, RL+2,   0, 0,      12'h000};
    vecs[7] = '{1'b0, 1'b0, 12'h0AB, 16'h0000, 16'h5555, 12'h0AB, RL+2,   0, 0,      12'h000};
    vecs[8] = '{1'b0, 1'b0, 12'h060, 16'h0000, 16'h0000, 12'h060, RL+2,   0, 0,      12'h000};

    // A store presented while reset is high must leave no trace (vector 8 reads it back).
    repeat (2) @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 12'h060;
    bus.req_wdata = 16'h1111;
    repeat (3) @(negedge clock);
    checkOutput("reset req_ready", bus.req_ready, 1);
    checkOutput("reset rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("reset rsp_ea", bus.rsp_ea, 0);
    checkOutput("reset mem_write", bus.mem_write, 0);
    checkOutput("reset mem_addr", bus.mem_addr, 0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 0);
`ifdef MEM_STATS_EN
    checkOutput("reset stat_reads", stat_reads, 0);
    checkOutput("reset stat_writes", stat_writes, 0);
`endif
    bus.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].write, vecs[v].ind, vecs[v].addr, vecs[v].wdata);
      checkOutput($sformatf("v%0d rsp_valid seen", v), got_rsp, 1);
      checkOutput($sformatf("v%0d latency", v), got_lat, vecs[v].exp_lat);
      checkOutput($sformatf("v%0d rsp_rdata", v), got_rdata, vecs[v].exp_rdata);
      checkOutput($sformatf("v%0d rsp_ea", v), got_ea, vecs[v].exp_ea);
      checkOutput($sformatf("v%0d mem_write cycles", v), wr_cycles, vecs[v].exp_wr_cycles);
      checkOutput($sformatf("v%0d rsp pulse width", v), rsp_after, 0);
      checkOutput($sformatf("v%0d req_ready after", v), ready_after, 1);
      if (vecs[v].write) begin
        checkOutput($sformatf("v%0d mem_write cycle", v), wr_lat, vecs[v].exp_wr_lat);
        checkOutput($sformatf("v%0d mem_write addr", v), wr_addr, vecs[v].exp_wr_addr);
        checkOutput($sformatf("v%0d mem_wdata", v), wr_data, vecs[v].wdata);
      end
    end

`ifdef MEM_STATS_EN
    checkOutput("stat_writes", stat_writes, 3);
    checkOutput("stat_reads", stat_reads, 6);
`endif

    // Three back-to-back loads with req_valid held high.
    acc = 0; rsp_cnt = 0; wr_cnt = 0; stall = 0; last_acc = -1; bad_rd = 0; drop = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (c == 0) begin
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_ind   = 1'b0;
        bus.req_addr  = 12'h010;
      end
      if (drop) bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (bus.rsp_rdata !== 16'h1234) bad_rd++;
      end
      if (bus.mem_write) wr_cnt++;
      if (bus.req_valid && !bus.req_ready) stall++;
      if (bus.req_valid && bus.req_ready) begin
        acc++;
        if (last_acc >= 0) checkOutput("b2b accept spacing", c - last_acc, RL + 3);
        last_acc = c;
        if (acc == 3) drop = 1'b1;
      end
    end
    checkOutput("b2b accepts", acc, 3);
    checkOutput("b2b rsp pulses", rsp_cnt, 3);
    checkOutput("b2b bad rdata", bad_rd, 0);
    checkOutput("b2b mem_write cycles", wr_cnt, 0);
    checkOutput("b2b stalled cycles", stall, 2 * (RL + 2));

    // Reset asserted while the store sits in ACC_WR.
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_ind   = 1'b0;
    bus.req_addr  = 12'h050;
    bus.req_wdata = 16'h7777;
    @(negedge clock);
    bus.req_valid = 1'b0;
    checkOutput("midrst mem_write before", bus.mem_write, 1);
    reset = 1'b1;
    #1;
    checkOutput("midrst mem_write dropped", bus.mem_write, 0);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midrst req_ready", bus.req_ready, 1);
    rsp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.rsp_valid) rsp_cnt++;
    end
    checkOutput("midrst rsp pulses", rsp_cnt, 0);
    applyStimulus(1'b0, 1'b0, 12'h050, 16'h0000);
    checkOutput("midrst readback seen", got_rsp, 1);
    checkOutput("midrst readback data", got_rdata, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
